// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS main control FSM (master) and its datapath (slave).
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       pc_write;
   logic       branch;
   logic       branch_ne;
   logic [1:0] pc_src;
   logic       IorD;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       alu_src_A;
   logic [1:0] alu_src_B;
   logic       imm_zext;
   logic [2:0] alu_control;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct,
      output pc_write, branch, branch_ne, pc_src, IorD, mem_write, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_A, alu_src_B, imm_zext, alu_control, illegal, state
   );

   modport slave (
      output opcode, funct,
      input  pc_write, branch, branch_ne, pc_src, IorD, mem_write, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_A, alu_src_B, imm_zext, alu_control, illegal, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore decode of the state register,
// memory wait states and illegal-instruction trap/skip handling.
module mc_control_fsm #(
   parameter int MEM_WAIT        = 0,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   mc_control_fsm_if.master bus
);
   localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(MEM_WAIT);
   localparam logic [WW-1:0] W_ZERO = {WW{1'b0}};
   localparam logic [WW-1:0] W_ONE  = WW'(1);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB = 4'd7,
      S_BRANCH  = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
      S_JAL     = 4'd12, S_TRAP   = 4'd13
   } state_t;

   localparam state_t S_ILLEGAL = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

   state_t          state_r;
   logic [WW-1:0]   wcnt_r;
   logic            trap_r;
   logic            last_s;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI,
         OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL: op_legal = 1'b1;
         default:                               op_legal = 1'b0;
      endcase
   endfunction

   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
         default:                                             funct_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_alu = 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] op);
      case (op)
         OP_ANDI: imm_alu = 3'b000;
         OP_ORI:  imm_alu = 3'b001;
         OP_SLTI: imm_alu = 3'b111;
         default: imm_alu = 3'b010;
      endcase
   endfunction

   assign last_s = (wcnt_r == W_LAST);

   // State, wait-counter and sticky-trap update; memory states hold until the counter is last.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= S_FETCH;
         wcnt_r  <= W_ZERO;
         trap_r  <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH, S_MEMRD, S_MEMWR: begin
               if (last_s) begin
                  wcnt_r  <= W_ZERO;
                  state_r <= (state_r == S_FETCH) ? S_DECODE :
                             (state_r == S_MEMRD) ? S_MEMWB : S_FETCH;
               end else begin
                  wcnt_r <= wcnt_r + W_ONE;
               end
            end
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW:                      state_r <= S_MEMADR;
                  OP_R:                              state_r <= S_EXECUTE;
                  OP_BEQ, OP_BNE:                    state_r <= S_BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_r <= S_IEXEC;
                  OP_J:                              state_r <= S_JUMP;
                  OP_JAL:                            state_r <= S_JAL;
                  default: begin
                     state_r <= S_ILLEGAL;
                     trap_r  <= TRAP_ON_ILLEGAL;
                  end
               endcase
            end
            S_MEMADR:  state_r <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_EXECUTE: begin
               if (funct_legal(bus.funct)) begin
                  state_r <= S_ALUWB;
               end else begin
                  state_r <= S_ILLEGAL;
                  trap_r  <= TRAP_ON_ILLEGAL;
               end
            end
            S_IEXEC:   state_r <= S_IWB;
            S_TRAP:    state_r <= S_TRAP;
            default: begin
               state_r <= S_FETCH;
               wcnt_r  <= W_ZERO;
            end
         endcase
      end
   end

   // Moore output decode from the state register (plus opcode/funct once the IR is held).
   always_comb begin
      bus.pc_write    = 1'b0;
      bus.branch      = 1'b0;
      bus.branch_ne   = 1'b0;
      bus.pc_src      = 2'b00;
      bus.IorD        = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.reg_dst     = 2'b00;
      bus.mem_to_reg  = 2'b00;
      bus.alu_src_A   = 1'b0;
      bus.alu_src_B   = 2'b00;
      bus.imm_zext    = 1'b0;
      bus.alu_control = 3'b000;
      bus.illegal     = 1'b0;
      bus.state       = state_r;
      case (state_r)
         S_FETCH: begin
            bus.alu_src_B   = 2'b01;
            bus.alu_control = 3'b010;
            bus.ir_write    = last_s;
            bus.pc_write    = last_s;
         end
         S_DECODE: begin
            bus.alu_src_B   = 2'b11;
            bus.alu_control = 3'b010;
            bus.illegal     = !TRAP_ON_ILLEGAL && !op_legal(bus.opcode);
         end
         S_MEMADR: begin
            bus.alu_src_A   = 1'b1;
            bus.alu_src_B   = 2'b10;
            bus.alu_control = 3'b010;
         end
         S_MEMRD:  bus.IorD = 1'b1;
         S_MEMWB: begin
            bus.mem_to_reg = 2'b01;
            bus.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            bus.IorD      = 1'b1;
            bus.mem_write = last_s;
         end
         S_EXECUTE: begin
            bus.alu_src_A   = 1'b1;
            bus.alu_control = funct_alu(bus.funct);
            bus.illegal     = !TRAP_ON_ILLEGAL && !funct_legal(bus.funct);
         end
         S_ALUWB: begin
            bus.reg_dst   = 2'b01;
            bus.reg_write = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_A   = 1'b1;
            bus.alu_control = 3'b110;
            bus.pc_src      = 2'b01;
            bus.branch      = (bus.opcode == OP_BEQ);
            bus.branch_ne   = (bus.opcode == OP_BNE);
         end
         S_IEXEC: begin
            bus.alu_src_A   = 1'b1;
            bus.alu_src_B   = 2'b10;
            bus.alu_control = imm_alu(bus.opcode);
            bus.imm_zext    = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
         end
         S_IWB:    bus.reg_write = 1'b1;
         S_JUMP: begin
            bus.pc_src   = 2'b10;
            bus.pc_write = 1'b1;
         end
         S_JAL: begin
            bus.pc_src     = 2'b10;
            bus.pc_write   = 1'b1;
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b10;
         end
         S_TRAP:   bus.illegal = trap_r;
         default:  bus.illegal = 1'b0;
      endcase
   end
endmodule
